// File: rtl/anti_theft_ctrl_n_pkg.sv
// Shared definitions for the anti-theft controller: state encodings and
// delay-register select codes.
package anti_theft_ctrl_n_pkg;

    typedef enum logic [2:0] {
        ARMED     = 3'd0,
        TRIGGERED = 3'd1,
        ALARM     = 3'd2,
        DISARMED  = 3'd3,
        WAIT_EXIT = 3'd4,
        ARM_DELAY = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_ARM   = 2'b00,
        SEL_DRV   = 2'b01,
        SEL_PASS  = 2'b10,
        SEL_ALARM = 2'b11
    } sel_t;

endpackage

// File: rtl/anti_theft_ctrl_n_sec_timer.sv
// One-second prescaler plus down-counter. Expiry fires on the tick that would
// take the counter from 1 to 0, i.e. exactly load_val seconds after a load.
module at_sec_timer #(
    parameter int CLK_PER_SEC = 1,
    parameter int TW          = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          hold,
    input  logic [TW-1:0] load_val,
    output logic          sec_tick,
    output logic          expired
);

    localparam int            PW      = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] presc_q;
    logic [TW-1:0] timer_q;

    assign sec_tick = (presc_q == PRE_MAX);
    // A held timer is pinned at load_val, so it can never expire.
    assign expired  = sec_tick && !hold && (timer_q == TW'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            timer_q <= '0;
        end else if (load || hold) begin
            presc_q <= '0;
            timer_q <= load_val;
        end else begin
            presc_q <= sec_tick ? '0 : presc_q + 1'b1;
            if (sec_tick && (timer_q != '0)) begin
                timer_q <= timer_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/anti_theft_ctrl_n.sv
// Vehicle anti-theft controller for N doors: arming FSM, programmable delays,
// siren and status LED decode, and the hidden-switch fuel-pump latch.
module anti_theft_ctrl_n
    import anti_theft_ctrl_n_pkg::*;
#(
    parameter int N_DOORS     = 2,
    parameter int TW          = 4,
    parameter int CLK_PER_SEC = 1,
    parameter int T_ARM_DEF   = 6,
    parameter int T_DRV_DEF   = 8,
    parameter int T_PASS_DEF  = 15,
    parameter int T_ALARM_DEF = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               brake,
    input  logic               hidden_sw,
    input  logic               ignition,
    input  logic [N_DOORS-1:0] doors,
    input  logic               reprogram,
    input  logic [1:0]         time_param_sel,
    input  logic [TW-1:0]      time_value,
    output logic               fuel_pump,
    output logic               siren,
    output logic               status,
    output logic [2:0]         state_o
);

    state_t        state_q, state_d;
    logic [TW-1:0] t_arm_q, t_drv_q, t_pass_q, t_alarm_q;
    logic          status_q, status_d;
    logic          pump_q;
    logic          exit_seen_q;

    logic          door_any;
    logic [TW-1:0] prog_val;
    logic          timer_load, timer_hold;
    logic [TW-1:0] timer_val, timer_load_val;
    logic          sec_tick, expired;

    assign door_any = |doors;
    assign prog_val = (time_value == '0) ? TW'(1) : time_value;

    // Delay registers
    always_ff @(posedge clock) begin
        if (reset) begin
            t_arm_q   <= TW'(T_ARM_DEF);
            t_drv_q   <= TW'(T_DRV_DEF);
            t_pass_q  <= TW'(T_PASS_DEF);
            t_alarm_q <= TW'(T_ALARM_DEF);
        end else if (reprogram) begin
            case (sel_t'(time_param_sel))
                SEL_ARM:   t_arm_q   <= prog_val;
                SEL_DRV:   t_drv_q   <= prog_val;
                SEL_PASS:  t_pass_q  <= prog_val;
                SEL_ALARM: t_alarm_q <= prog_val;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ARMED;
            status_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
        end
    end

    // Next state; timer_load marks every state entry plus the ARM_DELAY restart.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_val  = '0;
        if (reprogram) begin
            state_d    = ARMED;
            timer_load = 1'b1;
        end else begin
            case (state_q)
                ARMED: begin
                    if (door_any) begin
                        state_d    = TRIGGERED;
                        timer_load = 1'b1;
                        timer_val  = doors[0] ? t_drv_q : t_pass_q;
                    end
                end
                TRIGGERED: begin
                    if (ignition) begin
                        state_d    = DISARMED;
                        timer_load = 1'b1;
                    end else if (expired) begin
                        state_d    = ALARM;
                        timer_load = 1'b1;
                        timer_val  = t_alarm_q;
                    end
                end
                ALARM: begin
                    if (ignition) begin
                        state_d    = DISARMED;
                        timer_load = 1'b1;
                    end else if (expired && !door_any) begin
                        state_d    = ARMED;
                        timer_load = 1'b1;
                    end
                end
                DISARMED: begin
                    if (!ignition) begin
                        state_d    = WAIT_EXIT;
                        timer_load = 1'b1;
                    end
                end
                WAIT_EXIT: begin
                    if (ignition) begin
                        state_d    = DISARMED;
                        timer_load = 1'b1;
                    end else if (exit_seen_q && !door_any) begin
                        state_d    = ARM_DELAY;
                        timer_load = 1'b1;
                        timer_val  = t_arm_q;
                    end
                end
                ARM_DELAY: begin
                    if (ignition) begin
                        state_d    = DISARMED;
                        timer_load = 1'b1;
                    end else if (door_any) begin
                        timer_load = 1'b1;
                        timer_val  = t_arm_q;
                    end else if (expired) begin
                        state_d    = ARMED;
                        timer_load = 1'b1;
                    end
                end
                default: begin
                    state_d    = ARMED;
                    timer_load = 1'b1;
                end
            endcase
        end
    end

    // An open door keeps the alarm timer pinned at its full siren time.
    assign timer_hold     = (state_q == ALARM) && door_any;
    assign timer_load_val = timer_load ? timer_val : t_alarm_q;

    at_sec_timer #(
        .CLK_PER_SEC (CLK_PER_SEC),
        .TW          (TW)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load),
        .hold     (timer_hold),
        .load_val (timer_load_val),
        .sec_tick (sec_tick),
        .expired  (expired)
    );

    always_comb begin
        status_d = 1'b0;
        case (state_d)
            TRIGGERED, ALARM: status_d = 1'b1;
            ARMED:            status_d = timer_load ? 1'b0 : (status_q ^ sec_tick);
            default:          status_d = 1'b0;
        endcase
    end

    // Driver must open and close the door in WAIT_EXIT before arming starts.
    always_ff @(posedge clock) begin
        if (reset) begin
            exit_seen_q <= 1'b0;
        end else if (timer_load) begin
            exit_seen_q <= 1'b0;
        end else if ((state_q == WAIT_EXIT) && doors[0]) begin
            exit_seen_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pump_q <= 1'b0;
        end else if (!ignition) begin
            pump_q <= 1'b0;
        end else if (brake && hidden_sw) begin
            pump_q <= 1'b1;
        end
    end

    assign fuel_pump = pump_q;
    assign siren     = (state_q == ALARM);
    assign status    = status_q;
    assign state_o   = state_q;

endmodule
